fft_frame_scheduler: RTL

Shares one 8-point complex FFT core (16 × 32-bit words per frame, `next`/`next_out` framing) among `NUM_REQ` requesters. It does four things:
- Arbitrates round-robin between the requesters.
- Generates the core's `next` pulse and drives frame data one cycle later.
- Tracks in-flight frames in an ID FIFO.
- Returns each result frame tagged with the ID of its originating requester.

It sits between the convolution engine's frame producers and the `dft_top` instance.

---
 rtl/fft_sched_pkg.sv | 19 +
 rtl/fft_frame_scheduler_if.sv | 40 ++++
 rtl/fft_id_fifo.sv | 59 +++++
 rtl/fft_frame_scheduler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler.
// A frame is 16 x 32-bit words (8 complex points, real/imag interleaved).
// The FSM state enum is used by the scheduler top level.
package fft_sched_pkg;

  localparam int FFT_WORDS = 16;
  localparam int WORD_W    = 32;
  localparam int FRAME_W   = FFT_WORDS * WORD_W;

  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    NEXT,
    DATA,
    GAP
  } state_t;

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Bundle of all scheduler-facing signals.
// Requester side: req_valid/req_ready/req_data. Core side: fft_next/fft_x/fft_next_out/fft_y.
// Result side: out_valid/out_id/out_data, plus status inflight/err_orphan.
interface fft_frame_scheduler_if #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8
);
  import fft_sched_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  frame_t [NUM_REQ-1:0] req_data;

  logic   fft_next;
  frame_t fft_x;
  logic   fft_next_out;
  frame_t fft_y;

  logic            out_valid;
  logic [ID_W-1:0] out_id;
  frame_t          out_data;
  logic [CNT_W-1:0] inflight;
  logic            err_orphan;

  // master: requesters plus the FFT core (environment side)
  modport master (
    output req_valid, req_data, fft_next_out, fft_y,
    input  req_ready, fft_next, fft_x, out_valid, out_id, out_data, inflight, err_orphan
  );

  // slave: the scheduler itself
  modport slave (
    input  req_valid, req_data, fft_next_out, fft_y,
    output req_ready, fft_next, fft_x, out_valid, out_id, out_data, inflight, err_orphan
  );

endinterface

// File: rtl/fft_id_fifo.sv
// Synchronous FIFO of requester IDs for frames in flight in the FFT core.
// Latency: pushed entry visible at head next cycle; count updates one cycle after push/pop.
// Backpressure: push ignored when full, pop ignored when empty (caller gates both).
// Ports: clk, reset (sync, active-high), push/push_dat, pop/pop_dat (head), full, empty, count.
module fft_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];
  assign count   = cnt;

  // Storage needs no reset: entries are only read when cnt says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Shares one 8-point FFT core among NUM_REQ requesters with round-robin arbitration and ID tagging.
// Latency: handshake T -> fft_next T+1, frame on fft_x from T+1; fft_next_out U -> out_valid U+2.
// Backpressure: grants only in IDLE with fewer than MAX_INFLIGHT frames in flight; results cannot stall.
// Ports: clk, reset (sync, active-high), bus (slave modport of fft_frame_scheduler_if).
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int MIN_GAP      = 3
) (
  input  logic clk,
  input  logic reset,
  fft_frame_scheduler_if.slave bus
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int CNT_W    = $clog2(MAX_INFLIGHT) + 1;
  localparam int GAP_W    = $clog2(MIN_GAP + 1);
  // DATA loads the counter so that GAP occupies MIN_GAP-3 cycles (count down to zero).
  localparam int GAP_LOAD = (MIN_GAP > 3) ? (MIN_GAP - 4) : 0;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [GAP_W-1:0] gap_cnt;
  frame_t           frame_q;
  logic             fft_next_q;
  logic             pend_vld;
  logic [ID_W-1:0]  pend_id;
  logic             out_valid_q;
  logic [ID_W-1:0]  out_id_q;
  frame_t           out_data_q;
  logic             err_q;

  logic [NUM_REQ-1:0] ready;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W-1:0]    cand;
  int                 sel;

  logic               fifo_full;
  logic               fifo_empty;
  logic [ID_W-1:0]    head_id;
  logic [CNT_W-1:0]   inflight_w;

  // Round-robin search starting at ptr; the first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    sel       = 0;
    if (!reset && state == IDLE && !fifo_full) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sel = int'(ptr) + k;
        if (sel >= NUM_REQ) sel = sel - NUM_REQ;
        cand = ID_W'(sel);
        if (!grant_any && bus.req_valid[cand]) begin
          grant_any = 1'b1;
          grant_id  = cand;
        end
      end
    end
    ready    = NUM_REQ'(grant_any) << grant_id;
    next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // ready is only set for a valid requester, so grant_any is the handshake.
  fft_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_id_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (grant_any),
    .push_dat (grant_id),
    .pop      (bus.fft_next_out),
    .pop_dat  (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (inflight_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      gap_cnt     <= '0;
      frame_q     <= '0;
      fft_next_q  <= 1'b0;
      pend_vld    <= 1'b0;
      pend_id     <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state      <= NEXT;
            fft_next_q <= 1'b1;
            frame_q    <= bus.req_data[grant_id];
            ptr        <= next_ptr;
          end
        end
        NEXT: begin
          state      <= DATA;
          fft_next_q <= 1'b0;
        end
        DATA: begin
          if (MIN_GAP > 3) begin
            state   <= GAP;
            gap_cnt <= GAP_W'(GAP_LOAD);
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Return path: pop the ID on next_out, capture fft_y one cycle later.
      pend_vld <= bus.fft_next_out && !fifo_empty;
      if (bus.fft_next_out) begin
        if (fifo_empty) err_q   <= 1'b1;
        else            pend_id <= head_id;
      end

      out_valid_q <= pend_vld;
      if (pend_vld) begin
        out_data_q <= bus.fft_y;
        out_id_q   <= pend_id;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.fft_next   = fft_next_q;
  assign bus.fft_x      = frame_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_data   = out_data_q;
  assign bus.inflight   = inflight_w;
  assign bus.err_orphan = err_q;

endmodule
